param_gray_updown_counter: RTL
==============================

PARAM_GRAY_UPDOWN_COUNTER -- requirements
Module: param_gray_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 Parameter SATURATE, default 0: 0 means the count wraps at its limits; 1 means the count holds at its limits.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port enable, input, 1 bit: advance the count by one step this cycle.
REQ-006 Port up_down, input, 1 bit: step direction; 1 counts up, 0 counts down.
REQ-007 Port load, input, 1 bit: load a new count this cycle.
REQ-008 Port load_gray, input, WIDTH bits: Gray-coded load value.
REQ-009 Port binary_out, output, WIDTH bits: registered count in binary.
REQ-010 Port gray_out, output, WIDTH bits: registered count in reflected-binary Gray code.
REQ-011 Port limit_hit, output, 1 bit: registered one-cycle pulse; an enabled step hit a limit (wrapped or saturated).

Function
REQ-012 Priority, evaluated each rising edge of clk: rst first, then load, then enable; if none is active, all state holds.
REQ-013 Load: binary_out SHALL take gray2bin(load_gray) and gray_out SHALL take load_gray, both on the next edge, 1-cycle latency.
REQ-014 gray2bin: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1] XOR g[i] for i from WIDTH-2 down to 0.
REQ-015 Up step, enable=1 and up_down=1: binary_out becomes binary_out+1, arithmetic modulo 2^WIDTH.
REQ-016 Down step, enable=1 and up_down=0: binary_out becomes binary_out-1, arithmetic modulo 2^WIDTH.
REQ-017 Up-step limit is binary_out=2^WIDTH-1; down-step limit is binary_out=0.
REQ-018 Enabled step at the limit, SATURATE=0: the count wraps (max to 0 going up, 0 to max going down).
REQ-019 Enabled step at the limit, SATURATE=1: the count holds its value.
REQ-020 Invariant: gray_out SHALL equal binary_out XOR (binary_out>>1) in every cycle; gray_out is a flop output, never a combinational decode after the register.
REQ-021 Every enabled step that changes the count SHALL flip exactly one bit of gray_out.
REQ-022 limit_hit SHALL be 1 in the cycle after an enabled step taken at the limit, in both SATURATE modes; otherwise it is 0.
REQ-023 load together with enable in the same cycle: load wins, no step is taken, and limit_hit is 0 next cycle.
REQ-024 up_down SHALL be sampled only when enable=1; direction changes between steps need no idle cycle.
REQ-025 limit_hit does not stretch: consecutive enabled steps at the limit in saturate mode produce limit_hit=1 on every following cycle, with no merging logic.
REQ-026 No combinational path from any input to any output; all outputs are flop outputs.

Reset
REQ-027 rst=1 at a rising edge SHALL set binary_out=0, gray_out=0 and limit_hit=0 on that edge, regardless of load, enable and up_down.
REQ-028 Reset asserted mid-count SHALL discard any pending step or load in that cycle.
REQ-029 The first step after reset deassertion is taken on the first edge with rst=0 and enable=1.
REQ-030 No reset value depends on WIDTH or SATURATE, other than the vector widths.

Verification
REQ-031 Wrap-up, WIDTH=4, SATURATE=0: from reset, hold enable=1 and up_down=1 for 16 cycles.
- gray_out sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, then 0.
- limit_hit=1 exactly on the cycle showing 0 after 8.
REQ-032 Down wrap, WIDTH=4: from reset, one down step.
- binary_out=F, gray_out=8, limit_hit=1.
- A following up step gives binary_out=0, limit_hit=1.
REQ-033 Saturate, WIDTH=4, SATURATE=1: load_gray=8 (binary F), then three up steps.
- binary_out stays F and gray_out stays 8.
- limit_hit=1 for each of the three cycles after those steps.
REQ-034 Load priority: load=1, load_gray=5, enable=1, up_down=1 in the same cycle.
- Next cycle binary_out=6, gray_out=5, limit_hit=0.
REQ-035 Reset mid-operation: at count 9, assert rst together with load=1 and enable=1.
- Next cycle binary_out=0, gray_out=0, limit_hit=0.
REQ-036 Width sweep, WIDTH=2 and WIDTH=8: run random enable, up_down, load stimulus for 10k cycles.
- REQ-020 and REQ-021 hold every cycle.
- Results match a reference model.

Source files
------------

// File: rtl/param_gray_updown_counter.sv
//------------------------------------------------------------------------------
// Module      : param_gray_updown_counter
// Description : Up/down counter held in binary and Gray form in parallel
//               registers, with Gray-coded load and a wrap/saturate limit flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module param_gray_updown_counter #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] binary_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             limit_hit
);

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_max  = '1;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_limit;

    logic [WIDTH-1:0] w_load_bin;
    logic             w_at_limit;
    logic [WIDTH-1:0] w_stepped;
    logic [WIDTH-1:0] w_step_bin;
    logic [WIDTH-1:0] w_step_gray;

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_comb begin
        w_load_bin = gray_to_bin(load_gray);
        w_at_limit = up_down ? (r_bin == c_max) : (r_bin == c_zero);
        w_stepped  = up_down ? (r_bin + c_one) : (r_bin - c_one);
    end

    // Saturating variant freezes the count at a limit; wrap variant lets the
    // modulo arithmetic roll over naturally.
    generate
        if (SATURATE) begin : g_saturate
            assign w_step_bin = w_at_limit ? r_bin : w_stepped;
        end else begin : g_wrap
            assign w_step_bin = w_stepped;
        end
    endgenerate

    // Gray is encoded before the register so gray_out is a clean flop output.
    assign w_step_gray = w_step_bin ^ (w_step_bin >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin   <= c_zero;
            r_gray  <= c_zero;
            r_limit <= 1'b0;
        end else if (load) begin
            r_bin   <= w_load_bin;
            r_gray  <= load_gray;
            r_limit <= 1'b0;
        end else if (enable) begin
            r_bin   <= w_step_bin;
            r_gray  <= w_step_gray;
            r_limit <= w_at_limit;
        end else begin
            r_limit <= 1'b0;
        end
    end

    assign binary_out = r_bin;
    assign gray_out   = r_gray;
    assign limit_hit  = r_limit;

endmodule

`default_nettype wire
